// File: rtl/fixed_encoder_if.sv
// fixed_encoder_if -- sample/residual bundle for the fixed-order predictive encoder.
//
// Signals (names kept from the original port list):
//   iEnable   : iSample is valid this cycle
//   iStart    : one-cycle pulse, begins a new block and latches iOrder
//   iOrder    : predictor order 0..4 (5..7 illegal)
//   iSample   : signed PCM sample x[n]
//   oResidual : signed residual, or sign-extended warm-up sample
//   oValid    : oResidual/oWarmup valid this cycle
//   oWarmup   : oResidual carries a verbatim warm-up sample
//   oError    : sticky, an illegal order was latched
//
// Modports: master drives the sample side (producer), slave is the encoder.
interface fixed_encoder_if #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int RES_WIDTH    = SAMPLE_WIDTH + 5
);
    logic                           iEnable;
    logic                           iStart;
    logic [2:0]                     iOrder;
    logic signed [SAMPLE_WIDTH-1:0] iSample;
    logic signed [RES_WIDTH-1:0]    oResidual;
    logic                           oValid;
    logic                           oWarmup;
    logic                           oError;

    modport master (
        output iEnable, iStart, iOrder, iSample,
        input  oResidual, oValid, oWarmup, oError
    );

    modport slave (
        input  iEnable, iStart, iOrder, iSample,
        output oResidual, oValid, oWarmup, oError
    );
endinterface

// File: rtl/fixed_encoder.sv
// fixed_encoder -- fixed-order (0..4) polynomial predictive encoder.
//
// Each block starts with iStart, which latches the predictor order. The first
// "order" enabled samples are passed through verbatim (warm-up, oWarmup=1);
// every later enabled sample produces the order-p difference residual.
// Outputs are registered: a sample presented on a cycle appears on the bus
// outputs in the following cycle.
//
// Ports:
//   iClock : sole clock, rising edge
//   iReset : asynchronous, active-low reset
//   bus    : fixed_encoder_if.slave (sample input / residual output bundle)
module fixed_encoder #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int RES_WIDTH    = SAMPLE_WIDTH + 5
) (
    input  logic            iClock,
    input  logic            iReset,
    fixed_encoder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN
    } state_t;

    // Registered state
    state_t                      state;
    logic [2:0]                  order;
    logic [2:0]                  cnt;
    logic signed [RES_WIDTH-1:0] h1, h2, h3, h4;

    // Next-state values
    state_t                      state_next;
    logic [2:0]                  order_next;
    logic [2:0]                  cnt_next;
    logic signed [RES_WIDTH-1:0] h1_next, h2_next, h3_next, h4_next;
    logic signed [RES_WIDTH-1:0] res_next;
    logic                        valid_next;
    logic                        warm_next;
    logic                        error_next;

    // Context the current sample is processed in: either the registered
    // context, or a freshly cleared one when iStart is asserted this cycle.
    state_t                      eff_state;
    logic [2:0]                  eff_order;
    logic [2:0]                  eff_cnt;
    logic signed [RES_WIDTH-1:0] e1, e2, e3, e4;

    logic                        illegal;
    logic [2:0]                  start_order;
    logic [2:0]                  cnt_inc;
    logic                        accept;
    logic signed [RES_WIDTH-1:0] x;
    logic signed [RES_WIDTH-1:0] r1, r2, r3, r4;

    assign x = RES_WIDTH'(bus.iSample);

    // Illegal orders are encoded as order 0 and flagged on oError.
    assign illegal     = (bus.iOrder > 3'd4);
    assign start_order = illegal ? 3'd0 : bus.iOrder;

    // Start-of-block context override, so a sample arriving together with
    // iStart is already the first sample of the new block.
    always_comb begin
        eff_state = state;
        eff_order = order;
        eff_cnt   = cnt;
        e1        = h1;
        e2        = h2;
        e3        = h3;
        e4        = h4;
        if (bus.iStart) begin
            eff_order = start_order;
            eff_cnt   = '0;
            e1        = '0;
            e2        = '0;
            e3        = '0;
            e4        = '0;
            eff_state = (start_order == 3'd0) ? RUN : WARMUP;
        end
    end

    // Residuals: binomial difference coefficients built from shifts and adds
    // so every term stays at RES_WIDTH (exact for order 4 at full scale).
    assign r1 = x - e1;
    assign r2 = x - (e1 <<< 1) + e2;
    assign r3 = x - ((e1 <<< 1) + e1) + ((e2 <<< 1) + e2) - e3;
    assign r4 = x - (e1 <<< 2) + ((e2 <<< 2) + (e2 <<< 1)) - (e3 <<< 2) + e4;

    assign accept  = bus.iEnable && (eff_state != IDLE);
    assign cnt_inc = eff_cnt + 3'd1;

    // Next-state and output logic
    always_comb begin
        state_next = eff_state;
        order_next = eff_order;
        cnt_next   = eff_cnt;
        h1_next    = e1;
        h2_next    = e2;
        h3_next    = e3;
        h4_next    = e4;
        res_next   = '0;
        valid_next = accept;
        warm_next  = 1'b0;
        error_next = bus.oError | (bus.iStart & illegal);

        if (accept) begin
            // History moves only on accepted samples.
            h1_next = x;
            h2_next = e1;
            h3_next = e2;
            h4_next = e3;

            case (eff_state)
                WARMUP: begin
                    res_next  = x;
                    warm_next = 1'b1;
                    cnt_next  = cnt_inc;
                    if (cnt_inc == eff_order) begin
                        state_next = RUN;
                    end
                end
                RUN: begin
                    case (eff_order)
                        3'd1:    res_next = r1;
                        3'd2:    res_next = r2;
                        3'd3:    res_next = r3;
                        3'd4:    res_next = r4;
                        default: res_next = x;
                    endcase
                end
                default: begin
                    res_next = '0;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state         <= IDLE;
            order         <= '0;
            cnt           <= '0;
            h1            <= '0;
            h2            <= '0;
            h3            <= '0;
            h4            <= '0;
            bus.oResidual <= '0;
            bus.oValid    <= 1'b0;
            bus.oWarmup   <= 1'b0;
            bus.oError    <= 1'b0;
        end else begin
            state         <= state_next;
            order         <= order_next;
            cnt           <= cnt_next;
            h1            <= h1_next;
            h2            <= h2_next;
            h3            <= h3_next;
            h4            <= h4_next;
            bus.oResidual <= res_next;
            bus.oValid    <= valid_next;
            bus.oWarmup   <= warm_next;
            bus.oError    <= error_next;
        end
    end

endmodule

// File: doc/fixed_encoder.md
FIXED_ENCODER -- requirements
Module: fixed_encoder

Interface
REQ-001 SHALL have parameter SAMPLE_WIDTH, default 16: signed input sample width.
REQ-002 SHALL have parameter RES_WIDTH, default SAMPLE_WIDTH+5: signed residual width, exact for order 4 (|coeff| sum 16).
REQ-003 SHALL have port iClock, input, 1: sole clock; all state on rising edge.
REQ-004 SHALL have port iReset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port iEnable, input, 1: iSample valid this cycle.
REQ-006 SHALL have port iStart, input, 1: one-cycle pulse; begins a new block and latches iOrder.
REQ-007 SHALL have port iOrder, input, 3: fixed predictor order, 0..4 legal.
REQ-008 SHALL have port iSample, input, SAMPLE_WIDTH: signed PCM sample x[n].
REQ-009 SHALL have port oResidual, output, RES_WIDTH: signed residual, or sign-extended warm-up sample.
REQ-010 SHALL have port oValid, output, 1: oResidual/oWarmup valid this cycle.
REQ-011 SHALL have port oWarmup, output, 1: oResidual carries a verbatim warm-up sample.
REQ-012 SHALL have port oError, output, 1: sticky; illegal order latched.

Function
REQ-013 SHALL be the inverse of the fixed decoder: for decoder order p, an encoded stream fed back through it SHALL reproduce the input samples exactly.
REQ-014 SHALL keep a history x[n-1]..x[n-4], shifted only on iEnable=1 cycles.
REQ-015 SHALL compute residuals, all in RES_WIDTH signed arithmetic, no saturation:
  order 0: x[n]; order 1: x[n]-x[n-1]; order 2: x[n]-2x[n-1]+x[n-2];
  order 3: x[n]-3x[n-1]+3x[n-2]-x[n-3]; order 4: x[n]-4x[n-1]+6x[n-2]-4x[n-3]+x[n-4].
REQ-016 SHALL register outputs: sample accepted at edge k appears on oResidual/oValid after edge k+1 (latency 1); oValid=0 on cycles following iEnable=0.
REQ-017 SHALL implement states IDLE, WARMUP, RUN with a warm-up counter (0..4).
REQ-018 IDLE: outputs idle, no sample accepted; iStart -> latch order; -> WARMUP if order>0, else RUN.
REQ-019 WARMUP: each enabled sample output verbatim (sign-extended) with oWarmup=1, counter++; when counter reaches order -> RUN.
REQ-020 RUN: each enabled sample produces a residual with oWarmup=0; remains in RUN until iStart or reset.
REQ-021 iStart SHALL clear history and counter; if iEnable=1 in the same cycle, that sample SHALL be the first sample of the new block (warm-up sample 0, or residual for order 0).
REQ-022 iStart in WARMUP or RUN SHALL abandon the current block immediately; the order latched by that iStart SHALL apply.
REQ-023 iOrder changes outside an iStart cycle SHALL be ignored.
REQ-024 iOrder 5..7 at iStart SHALL set oError=1 (sticky until reset) and the block SHALL be encoded as order 0.
REQ-025 iEnable=1 in IDLE without iStart SHALL be ignored (no oValid).

Reset
REQ-026 iReset=0 SHALL asynchronously force IDLE, history=0, counter=0, latched order=0, oResidual=0, oValid=0, oWarmup=0, oError=0.
REQ-027 Reset release SHALL take effect at the next rising edge; reset mid-block discards the block, with no further oValid until the next iStart.

Verification
REQ-028 Order 0, iStart with samples 10,-7,-4,8 -> oResidual 10,-7,-4,8, oWarmup=0 on all, each 1 cycle late.
REQ-029 Order 1, samples 10,-7,-4,8 -> 10(warm-up), -17, 3, 12.
REQ-030 Order 2 -> 10,-7 (warm-up), 20, 9; order 3 -> 10,-7,-4 (warm-up), -11.
REQ-031 Order 4, samples 10,-7,-4,8,2 -> four warm-up samples, then -16; with iEnable gaps inserted, same values with oValid only after enabled cycles.
REQ-032 Order 4, samples 32767,-32768,32767,-32768,32767 -> residual +524280, no overflow.
REQ-033 Order 6 at iStart -> oError=1, order-0 behaviour; iReset=0 mid-RUN -> all outputs 0 immediately; a following iStart with order 1 restarts with warm-up.
